// File: rtl/regfile_pkg.sv
// Shared register-file constants and helpers, imported by the pipeline top and
// the multiport register file.
package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_REG_COUNT  = 16;
  localparam int DEFAULT_PC_INDEX   = 15;

  // Address bits needed to index count registers (count >= 2).
  function automatic int addr_width(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: PC select, same-cycle write bypass (highest
// write port wins) and busy qualification against a same-cycle writeback.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int AW          = 4,
  parameter int WRITE_PORTS = 1,
  parameter int PC_INDEX    = DEFAULT_PC_INDEX,
  parameter int BYPASS      = 1
) (
  input  logic [AW-1:0]                     addr,
  input  logic [DATA_WIDTH-1:0]             stored_data,
  input  logic                              stored_busy,
  input  logic [DATA_WIDTH-1:0]             pc_value,
  input  logic [WRITE_PORTS-1:0]            write_enable,
  input  logic [WRITE_PORTS*AW-1:0]         write_addr,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0]             data,
  output logic                              busy
);

  localparam logic [AW-1:0] PC_ADDR = AW'(PC_INDEX);

  logic                  hit;
  logic [DATA_WIDTH-1:0] fwd;

  always_comb begin
    hit = 1'b0;
    fwd = stored_data;
    // Ascending scan: the last matching (highest-index) port overrides.
    for (int j = 0; j < WRITE_PORTS; j++) begin
      if (BYPASS != 0 && write_enable[j] && write_addr[j*AW +: AW] == addr) begin
        hit = 1'b1;
        fwd = write_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (addr == PC_ADDR) begin
      data = pc_value;
      busy = 1'b0;
    end else begin
      data = fwd;
      busy = stored_busy & ~hit;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file with PC read-through, optional write-to-read bypass
// and a per-register busy scoreboard feeding the hazard unit.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int REG_COUNT   = DEFAULT_REG_COUNT,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 1,
  parameter int PC_INDEX    = DEFAULT_PC_INDEX,
  parameter int BYPASS      = 1,
  localparam int AW         = addr_width(REG_COUNT)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [READ_PORTS*AW-1:0]          readAddr,
  output logic [READ_PORTS*DATA_WIDTH-1:0]  readData,
  output logic [READ_PORTS-1:0]             readBusy,
  input  logic [WRITE_PORTS-1:0]            writeEnable,
  input  logic [WRITE_PORTS*AW-1:0]         writeAddr,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0] writeData,
  input  logic                              reserveEnable,
  input  logic [AW-1:0]                     reserveAddr,
  input  logic [DATA_WIDTH-1:0]             pcValue
);

  localparam logic [AW-1:0] PC_ADDR = AW'(PC_INDEX);

  logic [DATA_WIDTH-1:0]  regs [REG_COUNT];
  logic [REG_COUNT-1:0]   busy;
  logic [REG_COUNT-1:0]   busy_next;
  logic [WRITE_PORTS-1:0] write_live;

  // Writes issued while reset is held are never forwarded.
  assign write_live = reset ? '0 : writeEnable;

  always_comb begin
    busy_next = busy;
    for (int j = 0; j < WRITE_PORTS; j++) begin
      if (writeEnable[j]) busy_next[writeAddr[j*AW +: AW]] = 1'b0;
    end
    // Reserve applied last so a new producer outranks a retiring one.
    if (reserveEnable) busy_next[reserveAddr] = 1'b1;
    busy_next[PC_INDEX] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < REG_COUNT; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      for (int j = 0; j < WRITE_PORTS; j++) begin
        if (writeEnable[j] && writeAddr[j*AW +: AW] != PC_ADDR)
          regs[writeAddr[j*AW +: AW]] <= writeData[j*DATA_WIDTH +: DATA_WIDTH];
      end
      busy <= busy_next;
    end
  end

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_read
    logic [AW-1:0] addr;
    assign addr = readAddr[k*AW +: AW];

    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .AW         (AW),
      .WRITE_PORTS(WRITE_PORTS),
      .PC_INDEX   (PC_INDEX),
      .BYPASS     (BYPASS)
    ) u_port (
      .addr        (addr),
      .stored_data (regs[addr]),
      .stored_busy (busy[addr] & ~reset),
      .pc_value    (pcValue),
      .write_enable(write_live),
      .write_addr  (writeAddr),
      .write_data  (writeData),
      .data        (readData[k*DATA_WIDTH +: DATA_WIDTH]),
      .busy        (readBusy[k])
    );
  end

  // Only reachable when REG_COUNT is not a power of two.
  always_ff @(posedge clk) begin
    for (int k = 0; k < READ_PORTS; k++)
      assert (int'(readAddr[k*AW +: AW]) < REG_COUNT);
    for (int j = 0; j < WRITE_PORTS; j++)
      assert (!writeEnable[j] || int'(writeAddr[j*AW +: AW]) < REG_COUNT);
    assert (!reserveEnable || int'(reserveAddr) < REG_COUNT);
  end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
Parametrised successor to the pipeline register file: N read ports, M write ports, configurable width and depth. The PC register reads the externally supplied PC value. Adds optional same-cycle write-to-read bypass and a per-register busy scoreboard for hazard detection. Sits in the decode stage; writeback drives the write ports, and the hazard unit consumes the readBusy outputs.

Parameters:
DATA_WIDTH, 8, register and data width in bits
REG_COUNT, 16, number of architectural registers (power of two, >= 2)
READ_PORTS, 2, number of combinational read ports (1..4)
WRITE_PORTS, 1, number of write ports (1..2)
PC_INDEX, 15, register index that reads pcValue (must be < REG_COUNT)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only
AW (localparam), $clog2(REG_COUNT), address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
readAddr  in  READ_PORTS*AW  read addresses, port k at [k*AW +: AW]
readData  out  READ_PORTS*DATA_WIDTH  read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
readBusy  out  READ_PORTS  1 = addressed register has an outstanding reservation
writeEnable  in  WRITE_PORTS  per-port write strobe
writeAddr  in  WRITE_PORTS*AW  write addresses
writeData  in  WRITE_PORTS*DATA_WIDTH  write data
reserveEnable  in  1  mark reserveAddr busy (issue of a multi-cycle producer)
reserveAddr  in  AW  register to reserve
pcValue  in  DATA_WIDTH  value returned for reads of PC_INDEX (caller supplies any offset)

Behaviour:
- Reset (sync, active-high): all registers 0, all busy bits 0. During reset, readData still follows the read rules below: stored 0s, pcValue for PC_INDEX, no bypass. readBusy = 0.
- Write: on the rising edge with writeEnable[j]=1, reg[writeAddr[j]] <= writeData[j]; one-cycle write latency.
- Writes to PC_INDEX are discarded. The register is not stored and its busy bit is not affected.
- Both write ports to the same address in the same cycle: the higher port index wins, for storage and for bypass.
- Read (combinational, zero latency):
  - readAddr==PC_INDEX -> pcValue.
  - Otherwise, if BYPASS=1 and any enabled, non-reset write port targets the address this cycle -> that port's writeData (highest index wins).
  - Otherwise -> stored value.
- Scoreboard, per register, next state of busy[r]:
  - reset -> 0.
  - else reserveEnable && reserveAddr==r && r!=PC_INDEX -> 1. Reserve wins over a simultaneous write: the new producer is outstanding.
  - else any writeEnable[j] && writeAddr[j]==r -> 0.
  - else hold.
- readBusy[k]:
  - BYPASS=1: busy[readAddr[k]] AND NOT (a same-cycle write to that address). A same-cycle reserve does not set it combinationally.
  - BYPASS=0: busy[readAddr[k]], registered state only.
  - Always 0 for PC_INDEX.
- Reserve of an already-busy register: stays 1, with no counting (single outstanding producer per register).
- Address out of range (REG_COUNT not power of two) is disallowed; an assertion in simulation flags it.

Decomposition:
- Shared package regfile_pkg: default DATA_WIDTH/REG_COUNT constants, PC_INDEX default, function addr_width(). The pipeline top and this block both import it.
- Sub-module regfile_read_port: one instance per read port (generate loop). It performs PC select, bypass priority mux and busy qualification.
- Storage and scoreboard stay in the top module.

Test Plan:
- Defaults. Reset 1 cycle; write R3=9, then R6=5 (separate cycles); read ports 0/1 at R3/R6 -> 9/5, readBusy=00.
- PC read. pcValue=4, readAddr1=15 -> 4. Write R15=0xAA, then pcValue=12 -> reads 12. Internal R15 is never stored, confirmed by pcValue change tracking.
- Bypass. BYPASS=1: write R2=0x33 and read R2 the same cycle -> 0x33 before the edge. BYPASS=0 build, same stimulus -> old value 0 until after the edge.
- Write conflict. WRITE_PORTS=2: both ports write R5, port0=0x11, port1=0x22 -> bypass read 0x22, stored 0x22 after the edge.
- Scoreboard.
  - Reserve R7 -> next cycle readBusy=1 on a port reading R7.
  - Writeback R7=0x40 -> same-cycle readBusy=0 with data 0x40 (BYPASS=1); busy clears after the edge.
  - Simultaneous reserve+write R7 -> busy stays 1.
- Reset mid-operation. R4 busy and holding 0x9C; assert reset with a concurrent write R4=0x55 -> after the edge R4=0, busy=0. During reset the read returns 0 (no bypass).
